// File: rtl/ctrl_pkg.sv
// Shared control-unit constants for the microprogrammed MIPS datapath.
// Used by the sequencer and the instruction-to-state encoder.
package ctrl_pkg;

  localparam int STATE_W = 7;

  typedef enum logic [2:0] {
    NC_INC      = 3'd0,
    NC_DISPATCH = 3'd1,
    NC_JUMP     = 3'd2,
    NC_FETCH    = 3'd3,
    NC_COND     = 3'd4,
    NC_WAIT_MOC = 3'd5
  } next_ctl_e;

  localparam logic [STATE_W-1:0] RESET_STATE   = 7'd0;
  localparam logic [STATE_W-1:0] FETCH_STATE   = 7'd1;
  localparam logic [STATE_W-1:0] ILLEGAL_STATE = 7'd127;
  localparam logic [STATE_W-1:0] BUSERR_STATE  = 7'd126;

endpackage

// File: rtl/moc_watchdog.sv
// Counts consecutive cycles spent waiting on MOC.
// Pulses timeout on the last allowed wait cycle.
module moc_watchdog #(
  parameter int MOC_TIMEOUT = 16
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic waiting,
  input  logic MOC,
  output logic timeout
);

  localparam logic [15:0] LAST = 16'(MOC_TIMEOUT - 1);

  logic [15:0] cnt;
  logic        hold;

  assign timeout = waiting && !MOC && (cnt == LAST);
  assign hold    = waiting && !MOC && !timeout;

  // Any cycle that is not a hold changes State, so the count restarts.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cnt <= '0;
    else if (hold) cnt <= cnt + 16'd1;
    else           cnt <= '0;
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microstore state register and next-state logic.
// Handles dispatch, branches, MOC stalls and fault traps.
module micro_sequencer
  import ctrl_pkg::*;
#(
  parameter int MOC_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [6:0]  State_Sel,
  input  logic [2:0]  Next_Ctl,
  input  logic [6:0]  Jump_Target,
  input  logic        Cond,
  input  logic        MOC,
  input  logic        Clear_Fault,
  output logic [6:0]  State,
  output logic        Illegal_Op,
  output logic        Bus_Error,
  output logic [31:0] Dispatch_Count
);

  logic [6:0] state_nxt;
  logic       waiting;
  logic       timeout;
  logic       set_ill;
  logic       set_bus;
  logic       do_disp;

  assign waiting = (State != RESET_STATE) &&
                   (Next_Ctl == NC_WAIT_MOC);

  moc_watchdog #(
    .MOC_TIMEOUT(MOC_TIMEOUT)
  ) u_wdog (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .waiting(waiting),
    .MOC    (MOC),
    .timeout(timeout)
  );

  always_comb begin
    state_nxt = FETCH_STATE;
    set_ill   = 1'b0;
    set_bus   = 1'b0;
    do_disp   = 1'b0;
    if (State != RESET_STATE) begin
      case (Next_Ctl)
        NC_INC:  state_nxt = State + 7'd1;
        NC_DISPATCH: begin
          if (State_Sel != 7'd0) begin
            state_nxt = State_Sel;
            do_disp   = 1'b1;
          end else begin
            state_nxt = ILLEGAL_STATE;
            set_ill   = 1'b1;
          end
        end
        NC_JUMP: state_nxt = Jump_Target;
        NC_COND: state_nxt = Cond ? Jump_Target : State + 7'd1;
        NC_WAIT_MOC: begin
          if (MOC) begin
            state_nxt = State + 7'd1;
          end else if (timeout) begin
            state_nxt = BUSERR_STATE;
            set_bus   = 1'b1;
          end else begin
            state_nxt = State;
          end
        end
        default: state_nxt = FETCH_STATE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      State          <= RESET_STATE;
      Illegal_Op     <= 1'b0;
      Bus_Error      <= 1'b0;
      Dispatch_Count <= '0;
    end else begin
      State <= state_nxt;
      // A new fault takes priority over a simultaneous clear.
      Illegal_Op <= set_ill | (Illegal_Op & ~Clear_Fault);
      Bus_Error  <= set_bus | (Bus_Error & ~Clear_Fault);
      if (do_disp) Dispatch_Count <= Dispatch_Count + 32'd1;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed-vector bench for micro_sequencer.
// Expected values are hand-computed constants.
module tb_micro_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [6:0]  State_Sel;
  logic [2:0]  Next_Ctl;
  logic [6:0]  Jump_Target;
  logic        Cond;
  logic        MOC;
  logic        Clear_Fault;
  logic [6:0]  State;
  logic        Illegal_Op;
  logic        Bus_Error;
  logic [31:0] Dispatch_Count;

  int n_chk = 0;
  int n_err = 0;

  micro_sequencer #(.MOC_TIMEOUT(16)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .State_Sel     (State_Sel),
    .Next_Ctl      (Next_Ctl),
    .Jump_Target   (Jump_Target),
    .Cond          (Cond),
    .MOC           (MOC),
    .Clear_Fault   (Clear_Fault),
    .State         (State),
    .Illegal_Op    (Illegal_Op),
    .Bus_Error     (Bus_Error),
    .Dispatch_Count(Dispatch_Count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic jump_to(input logic [6:0] t);
    Next_Ctl    = 3'd2;
    Jump_Target = t;
    step();
  endtask

  initial begin
    Reset_n     = 1'b0;
    State_Sel   = '0;
    Next_Ctl    = 3'd0;
    Jump_Target = '0;
    Cond        = 1'b0;
    MOC         = 1'b0;
    Clear_Fault = 1'b0;
    #23;
    chk("rst_state", State, 0);
    chk("rst_ill", Illegal_Op, 0);
    chk("rst_bus", Bus_Error, 0);
    chk("rst_cnt", Dispatch_Count, 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    // INC walk from reset
    step(); chk("inc1", State, 1);
    step(); chk("inc2", State, 2);
    step(); chk("inc3", State, 3);
    chk("inc_ill", Illegal_Op, 0);
    chk("inc_cnt", Dispatch_Count, 0);

    // dispatch
    jump_to(7'd2);
    Next_Ctl = 3'd1; State_Sel = 7'd6;
    step(); chk("disp_addu", State, 6);
    chk("disp_cnt1", Dispatch_Count, 1);
    State_Sel = 7'd13;
    step(); chk("disp_lw", State, 13);
    chk("disp_cnt2", Dispatch_Count, 2);
    State_Sel = 7'd0;
    step(); chk("disp_ill_st", State, 127);
    chk("disp_ill_flag", Illegal_Op, 1);
    chk("disp_ill_cnt", Dispatch_Count, 2);

    // clear vs hold state
    Next_Ctl = 3'd2; Jump_Target = 7'd127; Clear_Fault = 1'b1;
    step(); chk("clr_ill", Illegal_Op, 0);
    chk("clr_state", State, 127);
    // set wins over clear
    Next_Ctl = 3'd1; State_Sel = 7'd0;
    step(); chk("setwin_ill", Illegal_Op, 1);
    chk("setwin_st", State, 127);
    Next_Ctl = 3'd2;
    step(); chk("clr_ill2", Illegal_Op, 0);
    Clear_Fault = 1'b0;

    // 127 wraps to 0; state 0 ignores Next_Ctl
    Next_Ctl = 3'd0;
    step(); chk("wrap", State, 0);
    Next_Ctl = 3'd1; State_Sel = 7'd0;
    step(); chk("st0_fetch", State, 1);
    chk("st0_noill", Illegal_Op, 0);
    chk("st0_cnt", Dispatch_Count, 2);

    // COND
    jump_to(7'd11);
    Next_Ctl = 3'd4; Jump_Target = 7'd40; Cond = 1'b1;
    step(); chk("cond_t", State, 40);
    jump_to(7'd11);
    Next_Ctl = 3'd4; Jump_Target = 7'd40; Cond = 1'b0;
    step(); chk("cond_f", State, 12);

    // WAIT_MOC, MOC after 5 cycles
    jump_to(7'd14);
    Next_Ctl = 3'd5; MOC = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("wait5_hold", State, 14);
    MOC = 1'b1;
    step(); chk("wait5_adv", State, 15);
    chk("wait5_bus", Bus_Error, 0);
    MOC = 1'b0;

    // WAIT_MOC timeout
    jump_to(7'd14);
    Next_Ctl = 3'd5;
    for (int i = 0; i < 15; i++) step();
    chk("to_hold15", State, 14);
    chk("to_bus15", Bus_Error, 0);
    step(); chk("to_state", State, 126);
    chk("to_bus", Bus_Error, 1);
    Next_Ctl = 3'd2; Jump_Target = 7'd126; Clear_Fault = 1'b1;
    step(); chk("clr_bus", Bus_Error, 0);
    chk("clr_bus_st", State, 126);
    Clear_Fault = 1'b0;

    // MOC on the timeout cycle wins
    jump_to(7'd14);
    Next_Ctl = 3'd5;
    for (int i = 0; i < 15; i++) step();
    MOC = 1'b1;
    step(); chk("mocwin_st", State, 15);
    chk("mocwin_bus", Bus_Error, 0);
    MOC = 1'b0;

    // FETCH and reserved codes
    Next_Ctl = 3'd3;
    step(); chk("fetch", State, 1);
    jump_to(7'd20);
    Next_Ctl = 3'd6;
    step(); chk("rsv6", State, 1);
    jump_to(7'd20);
    Next_Ctl = 3'd7;
    step(); chk("rsv7", State, 1);
    chk("rsv_ill", Illegal_Op, 0);

    // async reset mid-wait
    jump_to(7'd14);
    Next_Ctl = 3'd5;
    for (int i = 0; i < 9; i++) step();
    chk("mid_hold", State, 14);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_st", State, 0);
    chk("async_cnt", Dispatch_Count, 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    step(); chk("post_rst", State, 1);
    jump_to(7'd14);
    Next_Ctl = 3'd5;
    for (int i = 0; i < 15; i++) step();
    chk("fresh_hold", State, 14);
    chk("fresh_bus0", Bus_Error, 0);
    step(); chk("fresh_to", State, 126);
    chk("fresh_bus1", Bus_Error, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Control-unit state register and next-state logic for the microprogrammed MIPS datapath.
- Consumes the 7-bit dispatch state produced by the instruction-to-state encoder (e.g. ADDU=6, SW=7, BEQ=11, LW=13).
- Walks the microstore address space under the microinstruction's next-state control, stalls on memory handshakes, and traps illegal opcodes and memory timeouts.
- Drives State, which addresses the microstore ROM.

Parameters:
- STATE_W, 7, width of state/microstore address.
- FETCH_STATE, 7'd1, first state of the instruction fetch microroutine.
- ILLEGAL_STATE, 7'd127, trap target on dispatch of an unrecognised opcode.
- BUSERR_STATE, 7'd126, trap target on memory handshake timeout.
- MOC_TIMEOUT, 16, maximum cycles waited for MOC; legal range is 2 to 65535.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- State_Sel  in  7  dispatch target from encoder; 0 means unrecognised instruction.
- Next_Ctl  in  3  next-state code from current microinstruction.
- Jump_Target  in  7  target for JUMP and COND from current microinstruction.
- Cond  in  1  branch condition, e.g. ALU zero for BEQ or sign for BGEZ.
- MOC  in  1  memory operation complete.
- Clear_Fault  in  1  synchronous clear of sticky fault flags.
- State  out  7  current state, registered.
- Illegal_Op  out  1  sticky: an illegal dispatch occurred.
- Bus_Error  out  1  sticky: an MOC timeout occurred.
- Dispatch_Count  out  32  number of successful dispatches, wraps at 2^32.

Behaviour:
- Reset (async, Reset_n=0): State=0, Illegal_Op=0, Bus_Error=0, Dispatch_Count=0, watchdog count=0.
- State 0 is the reset state: the next edge goes to FETCH_STATE unconditionally, and Next_Ctl is ignored.
- All other states update State on each rising edge from Next_Ctl:
  - 0 INC: State+1, modulo 128 (127 -> 0 is legal).
  - 1 DISPATCH: State_Sel if nonzero, and Dispatch_Count+1. If State_Sel=0: ILLEGAL_STATE, set Illegal_Op, count unchanged.
  - 2 JUMP: Jump_Target.
  - 3 FETCH: FETCH_STATE.
  - 4 COND: Cond ? Jump_Target : State+1.
  - 5 WAIT_MOC: if MOC=1, State+1. Otherwise, if watchdog = MOC_TIMEOUT-1, go to BUSERR_STATE and set Bus_Error. Otherwise hold State and increment watchdog.
  - 6, 7 reserved: behave as FETCH, no flag.
- Watchdog:
  - Counts only consecutive WAIT_MOC hold cycles.
  - Cleared on any edge where State changes, and on reset.
  - Total wait cycles before the trap = MOC_TIMEOUT.
- Simultaneous events:
  - MOC=1 on the timeout cycle: MOC wins, no trap.
  - Clear_Fault together with a new fault: set wins, flag stays 1.
- Clear_Fault clears only the flags; it does not change State.
- Trap states are ordinary states, and their microcode supplies Next_Ctl.
- Reset asserted mid-WAIT or mid-routine: immediate return to State=0 and all counters 0, with no partial update.
- Outputs are all registered, with no combinational path from inputs to outputs.
- Latency is 1 cycle from the Next_Ctl/State_Sel sample edge to the new State.

Decomposition:
- Shared package (ctrl_pkg):
  - Next_Ctl codes NC_INC, NC_DISPATCH, NC_JUMP, NC_FETCH, NC_COND, NC_WAIT_MOC.
  - State constants RESET_STATE=0, FETCH_STATE, ILLEGAL_STATE, BUSERR_STATE.
  - STATE_W.
  - The encoder uses the same state constants.
- One sub-module, moc_watchdog:
  - Inputs: Clk, Reset_n, waiting, MOC.
  - Output: timeout pulse.
  - Parameter: MOC_TIMEOUT.

Test Plan:
- Reset release, then Next_Ctl=INC for 3 edges -> State 0,1,2,3; flags 0; Dispatch_Count=0.
- From State=2, Next_Ctl=DISPATCH, State_Sel=6 (ADDU) -> State=6, Dispatch_Count=1; repeat with State_Sel=13 (LW) -> State=13, Dispatch_Count=2.
- DISPATCH with State_Sel=0 -> State=127, Illegal_Op=1, Dispatch_Count unchanged; Clear_Fault=1 one cycle -> Illegal_Op=0, State unchanged.
- COND at State=11, Jump_Target=40: Cond=1 -> State=40; Cond=0 -> State=12.
- WAIT_MOC at State=14:
  - MOC rises after 5 cycles -> State holds 14 for 5 cycles, then 15, Bus_Error=0.
  - MOC never rises -> after 16 cycles State=126, Bus_Error=1.
  - MOC=1 on the 16th cycle -> State=15, no trap.
- Reset_n pulsed low mid-WAIT (watchdog=9) -> State=0 asynchronously; after release a fresh WAIT needs the full 16 cycles before trapping.
